obi_mem_arbiter: RTL and testbench
==================================

OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 Param NUM_MASTERS, default 2, number of OBI master ports (range 2..8).
REQ-002 Param MAX_OUTSTANDING, default 2, response-routing FIFO depth; power of two, range 1..16.
REQ-003 Param ADDR_WIDTH, default 32, address width.
REQ-004 Param DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 m_req_i  in  NUM_MASTERS  per-master request.
REQ-008 m_gnt_o  out  NUM_MASTERS  per-master grant.
REQ-009 m_addr_i / m_be_i / m_we_i / m_wdata_i  in  NUM_MASTERS x width (packed arrays)  per-master request payload.
REQ-010 m_rvalid_o  out  NUM_MASTERS  per-master response valid.
REQ-011 m_rdata_o  out  NUM_MASTERS x DATA_WIDTH  per-master response data.
REQ-012 mem_req_o / mem_addr_o / mem_be_o / mem_we_o / mem_wdata_o  out  1/ADDR/BE/1/DATA  downstream request.
REQ-013 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1/1/DATA  downstream grant and response.
REQ-014 outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  accepted-but-unanswered transaction count.

Function
REQ-015 mem_req_o SHALL equal OR of m_req_i gated by (outstanding_o < MAX_OUTSTANDING); combinational, zero-latency.
REQ-016 Payload outputs SHALL be driven from the selected master; all-zero when mem_req_o is low.
REQ-017 m_gnt_o[i] SHALL be high only when i is selected, mem_req_o high and mem_gnt_i high; at most one bit set.
REQ-018 Handshake = mem_req_o & mem_gnt_i; on handshake the selected index SHALL be pushed into the FIFO.
REQ-019 On mem_rvalid_i the FIFO head SHALL be popped; m_rvalid_o[head]=1 and m_rdata_o[head]=mem_rdata_i in the same cycle; other rvalid bits 0.
REQ-020 Responses SHALL be routed strictly in acceptance order (in-order downstream).
REQ-021 Full: count==MAX_OUTSTANDING blocks mem_req_o even if a pop occurs that cycle (no rvalid->req combinational path).
REQ-022 Simultaneous push and pop below full: count unchanged, both take effect.
REQ-023 mem_rvalid_i with empty FIFO SHALL be ignored (no m_rvalid_o, count stays 0); bench flags it as an error.
REQ-024 Lock FSM, states IDLE/LOCKED: IDLE->LOCKED when mem_req_o & !mem_gnt_i, registering the selected index; LOCKED->IDLE on handshake; in LOCKED the registered index SHALL be selected regardless of other requests.
REQ-025 Wrap: FIFO pointers wrap modulo MAX_OUTSTANDING; count never exceeds MAX_OUTSTANDING.

Reset
REQ-026 During reset (and the first cycle after release) FIFO empty, count 0, FSM IDLE, priority pointer 0.
REQ-027 All outputs SHALL be 0 while rst_i is high.
REQ-028 Reset mid-transaction SHALL discard pending responses; later mem_rvalid_i is ignored per REQ-023.

Configuration
REQ-029 Macro OBI_ARB_ROUND_ROBIN_EN defined: round-robin selection, search starts at pointer; pointer := granted index+1 (mod NUM_MASTERS) on each handshake.
REQ-030 Macro undefined: fixed priority, lowest index wins; pointer logic absent; lock FSM still present.

Structure
REQ-031 Shared package obi_arb_pkg SHALL hold the lock-FSM state enum and the index-width helper constant function.
REQ-032 Sub-module obi_arb_fifo (index FIFO, depth MAX_OUTSTANDING, push/pop/count/full/empty) SHALL be instantiated once.

Verification
REQ-033 M0 req addr 0x100, mem_gnt same cycle -> m_gnt_o=01, next-cycle mem_rvalid rdata 0xDEADBEEF -> m_rvalid_o=01, m_rdata_o[0]=0xDEADBEEF.
REQ-034 RR build, M0 and M1 req continuously, gnt always 1 -> grants alternate 01,10,01,10.
REQ-035 MAX_OUTSTANDING=2, two handshakes, no rvalid -> outstanding_o=2, mem_req_o=0 despite req; one rvalid -> count 1, req resumes next cycle.
REQ-036 M1 req with mem_gnt_i=0 three cycles, M0 asserts in cycle 2 -> mem_addr_o stays M1's for all cycles, M1 granted first.
REQ-037 Interleaved grants M1,M0,M1 then three rvalids 0xA,0xB,0xC -> delivered to M1,M0,M1 in that order.
REQ-038 rst_i pulsed with two outstanding, then mem_rvalid_i -> no m_rvalid_o, outstanding_o=0.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI memory arbiter.
package obi_arb_pkg;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  // Bits needed to index n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_arb_fifo.sv
// Index FIFO recording which master owns each accepted-but-unanswered transaction.
module obi_arb_fifo
  import obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = idx_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Overflowing pushes and underflowing pops are dropped.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign wr_ptr_nxt = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_nxt = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_nxt;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// N-to-1 OBI arbiter onto a single in-order memory port with per-response routing.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (index 0 highest).
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NUM_MASTERS-1:0]                      m_req_i,
  output logic [NUM_MASTERS-1:0]                      m_gnt_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]    m_be_i,
  input  logic [NUM_MASTERS-1:0]                      m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_wdata_i,
  output logic [NUM_MASTERS-1:0]                      m_rvalid_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_rdata_o,
  output logic                                        mem_req_o,
  output logic [ADDR_WIDTH-1:0]                       mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]                     mem_be_o,
  output logic                                        mem_we_o,
  output logic [DATA_WIDTH-1:0]                       mem_wdata_o,
  input  logic                                        mem_gnt_i,
  input  logic                                        mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                       mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]            outstanding_o
);

  localparam int unsigned IW = idx_width(NUM_MASTERS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  lock_state_e   lock_state;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] head_idx;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          handshake;
  logic          pop;

`ifdef OBI_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;
  logic          arb_found;

  // Rotating search: first requester at or after the pointer wins.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (!arb_found && m_req_i[(32'(rr_ptr) + k) % NUM_MASTERS]) begin
        arb_idx   = IW'((32'(rr_ptr) + k) % NUM_MASTERS);
        arb_found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scan downwards so the lowest requesting index wins.
  always_comb begin
    arb_idx = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (m_req_i[i]) begin
        arb_idx = IW'(i);
      end
    end
  end
`endif

  assign sel_idx   = (lock_state == LOCK_LOCKED) ? lock_idx : arb_idx;
  assign mem_req_o = ~rst_i & (|m_req_i) & ~fifo_full;
  assign handshake = mem_req_o & mem_gnt_i;
  assign pop       = ~rst_i & mem_rvalid_i & ~fifo_empty;

  assign mem_addr_o    = mem_req_o ? m_addr_i[sel_idx]  : '0;
  assign mem_be_o      = mem_req_o ? m_be_i[sel_idx]    : '0;
  assign mem_we_o      = mem_req_o ? m_we_i[sel_idx]    : 1'b0;
  assign mem_wdata_o   = mem_req_o ? m_wdata_i[sel_idx] : '0;
  assign outstanding_o = rst_i ? '0 : fifo_count;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    if (handshake) begin
      m_gnt_o[sel_idx] = 1'b1;
    end
    if (pop) begin
      m_rvalid_o[head_idx] = 1'b1;
      m_rdata_o[head_idx]  = mem_rdata_i;
    end
  end

  // A stalled request keeps its master selected until the memory grants it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_state <= LOCK_IDLE;
      lock_idx   <= '0;
    end else begin
      case (lock_state)
        LOCK_IDLE: begin
          if (mem_req_o && !mem_gnt_i) begin
            lock_state <= LOCK_LOCKED;
            lock_idx   <= sel_idx;
          end
        end
        LOCK_LOCKED: begin
          if (handshake) begin
            lock_state <= LOCK_IDLE;
          end
        end
        default: lock_state <= LOCK_IDLE;
      endcase
    end
  end

`ifdef OBI_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (sel_idx == IW'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`endif

  obi_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (handshake),
    .push_data_i (sel_idx),
    .pop_i       (pop),
    .head_o      (head_idx),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed vector table, corner sequences, random vs queue model.
module tb_obi_mem_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        m_req;
  logic [1:0]        m_gnt;
  logic [1:0][31:0]  m_addr;
  logic [1:0][3:0]   m_be;
  logic [1:0]        m_we;
  logic [1:0][31:0]  m_wdata;
  logic [1:0]        m_rvalid;
  logic [1:0][31:0]  m_rdata;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [1:0]        outstanding;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  obi_mem_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_req_i       (m_req),
    .m_gnt_o       (m_gnt),
    .m_addr_i      (m_addr),
    .m_be_i        (m_be),
    .m_we_i        (m_we),
    .m_wdata_i     (m_wdata),
    .m_rvalid_o    (m_rvalid),
    .m_rdata_o     (m_rdata),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_be_o      (mem_be),
    .mem_we_o      (mem_we),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .outstanding_o (outstanding)
  );

  // Reference model: queue of owning master per accepted transaction.
  int mdl_q[$];
  bit mdl_locked;
  int mdl_lock_idx;
`ifdef OBI_ARB_ROUND_ROBIN_EN
  int mdl_ptr;
`endif

  logic             e_req;
  logic [1:0]       e_gnt;
  logic [31:0]      e_addr;
  logic [3:0]       e_be;
  logic             e_we;
  logic [31:0]      e_wdata;
  logic [1:0]       e_rvalid;
  logic [1:0][31:0] e_rdata;
  logic [1:0]       e_out;
  int               e_sel;
  bit               e_hs;
  bit               e_pop;

  function automatic int model_sel();
    if (mdl_locked) return mdl_lock_idx;
`ifdef OBI_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (m_req[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (m_req[k]) return k;
`endif
    return 0;
  endfunction

  function automatic void model_eval();
    e_sel    = model_sel();
    e_req    = !rst && (m_req != 2'b00) && (mdl_q.size() < MAXO);
    e_hs     = e_req && mem_gnt;
    e_pop    = !rst && mem_rvalid && (mdl_q.size() > 0);
    e_gnt    = e_hs ? 2'(1 << e_sel) : 2'b00;
    e_addr   = e_req ? m_addr[e_sel] : 32'h0;
    e_be     = e_req ? m_be[e_sel] : 4'h0;
    e_we     = e_req ? m_we[e_sel] : 1'b0;
    e_wdata  = e_req ? m_wdata[e_sel] : 32'h0;
    e_rvalid = 2'b00;
    e_rdata  = '0;
    if (e_pop) begin
      e_rvalid = 2'(1 << mdl_q[0]);
      e_rdata[mdl_q[0]] = mem_rdata;
    end
    e_out = rst ? 2'd0 : 2'(mdl_q.size());
  endfunction

  function automatic void model_update();
    int tmp;
    if (rst) begin
      mdl_q.delete();
      mdl_locked = 1'b0;
`ifdef OBI_ARB_ROUND_ROBIN_EN
      mdl_ptr = 0;
`endif
    end else begin
      if (e_pop) tmp = mdl_q.pop_front();
      if (e_hs) begin
        mdl_q.push_back(e_sel);
`ifdef OBI_ARB_ROUND_ROBIN_EN
        mdl_ptr = (e_sel + 1) % N;
`endif
      end
      if (!mdl_locked && e_req && !mem_gnt) begin
        mdl_locked   = 1'b1;
        mdl_lock_idx = e_sel;
      end else if (mdl_locked && e_hs) begin
        mdl_locked = 1'b0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model();
    check("rnd_mem_req",   64'(mem_req),     64'(e_req));
    check("rnd_mem_addr",  64'(mem_addr),    64'(e_addr));
    check("rnd_mem_be",    64'(mem_be),      64'(e_be));
    check("rnd_mem_we",    64'(mem_we),      64'(e_we));
    check("rnd_mem_wdata", 64'(mem_wdata),   64'(e_wdata));
    check("rnd_m_gnt",     64'(m_gnt),       64'(e_gnt));
    check("rnd_m_rvalid",  64'(m_rvalid),    64'(e_rvalid));
    check("rnd_m_rdata",   64'(m_rdata),     64'(e_rdata));
    check("rnd_outst",     64'(outstanding), 64'(e_out));
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        x_req;
    logic [1:0]  x_gnt;
    logic [31:0] x_addr;
    logic [1:0]  x_rvalid;
    logic [31:0] x_rd0;
    logic [31:0] x_rd1;
    logic [1:0]  x_out;
  } vec_t;

  vec_t tbl[18];
  logic [1:0] rr_exp[4];

  initial begin
    rst = 1'b1; m_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    m_addr[0] = 32'h100; m_addr[1] = 32'h200;
    m_be = 8'h3F; m_we = 2'b10;
    m_wdata[0] = 32'h1111_0000; m_wdata[1] = 32'h2222_0000;

    //          rst req   gnt  rv  rdata          req  gnt   addr    rv    rd0            rd1     out
    tbl[0]  = '{1'b1, 2'b01, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0,   2'b00, 32'h0,         32'h0, 2'd0};
    tbl[1]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0, 2'd0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 2'b00, 32'h0,   2'b01, 32'hDEADBEEF,  32'h0, 2'd1};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0, 2'd0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0, 2'd1};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0,   2'b00, 32'h0,         32'h0, 2'd2};
    tbl[6]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'h11,        1'b0, 2'b00, 32'h0,   2'b01, 32'h11,        32'h0, 2'd2};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0, 2'd1};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h22,        1'b0, 2'b00, 32'h0,   2'b01, 32'h22,        32'h0, 2'd2};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h33,        1'b0, 2'b00, 32'h0,   2'b01, 32'h33,        32'h0, 2'd1};
    tbl[10] = '{1'b0, 2'b10, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 32'h200, 2'b00, 32'h0,         32'h0, 2'd0};
    tbl[11] = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0, 2'd1};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'hA,         1'b0, 2'b00, 32'h0,   2'b10, 32'h0,         32'hA, 2'd2};
    tbl[13] = '{1'b0, 2'b10, 1'b1, 1'b1, 32'hB,         1'b1, 2'b10, 32'h200, 2'b01, 32'hB,         32'h0, 2'd1};
    tbl[14] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'hC,         1'b0, 2'b00, 32'h0,   2'b10, 32'h0,         32'hC, 2'd1};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0,   2'b00, 32'h0,         32'h0, 2'd0};
    tbl[16] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h55,        1'b0, 2'b00, 32'h0,   2'b00, 32'h0,         32'h0, 2'd0};
    tbl[17] = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0,   2'b00, 32'h0,         32'h0, 2'd0};

`ifdef OBI_ARB_ROUND_ROBIN_EN
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
`else
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b01; rr_exp[3] = 2'b01;
`endif

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; m_req = tbl[i].req; mem_gnt = tbl[i].gnt;
      mem_rvalid = tbl[i].rvalid; mem_rdata = tbl[i].rdata;
      sample();
      check($sformatf("vec%0d_req", i),    64'(mem_req),     64'(tbl[i].x_req));
      check($sformatf("vec%0d_gnt", i),    64'(m_gnt),       64'(tbl[i].x_gnt));
      check($sformatf("vec%0d_addr", i),   64'(mem_addr),    64'(tbl[i].x_addr));
      check($sformatf("vec%0d_rvalid", i), 64'(m_rvalid),    64'(tbl[i].x_rvalid));
      check($sformatf("vec%0d_rdata", i),  64'(m_rdata),     {tbl[i].x_rd1, tbl[i].x_rd0});
      check($sformatf("vec%0d_outst", i),  64'(outstanding), 64'(tbl[i].x_out));
      commit();
    end

    // Stalled M1 stays selected while M0 joins; M1 is granted first.
    mem_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_req = (c == 0) ? 2'b10 : 2'b11;
      mem_gnt = (c == 3);
      sample();
      check($sformatf("lock%0d_addr", c), 64'(mem_addr), 64'h200);
      check($sformatf("lock%0d_gnt", c),  64'(m_gnt),    (c == 3) ? 64'h2 : 64'h0);
      commit();
    end
    m_req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    sample();
    check("lock_resp_rvalid", 64'(m_rvalid), 64'h2);
    commit();

    // Reset with two outstanding discards them; a later rvalid is ignored.
    mem_rvalid = 1'b0; m_req = 2'b01; mem_gnt = 1'b1;
    sample(); commit();
    sample(); commit();
    m_req = 2'b00; mem_gnt = 1'b0;
    sample();
    check("rstmid_outst_before", 64'(outstanding), 64'd2);
    commit();
    rst = 1'b1;
    sample();
    check("rstmid_outst_during", 64'(outstanding), 64'd0);
    commit();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    sample();
    check("rstmid_rvalid_after", 64'(m_rvalid),    64'h0);
    check("rstmid_outst_after",  64'(outstanding), 64'd0);
    commit();

    // Both masters requesting with memory always granting.
    m_req = 2'b11; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = (k > 0);
      sample();
      check($sformatf("arb%0d_gnt", k), 64'(m_gnt), 64'(rr_exp[k]));
      commit();
    end
    m_req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    sample(); commit();
    mem_rvalid = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      m_req      = 2'($urandom);
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (mdl_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      m_addr[0]  = $urandom; m_addr[1] = $urandom;
      m_be       = 8'($urandom);
      m_we       = 2'($urandom);
      m_wdata[0] = $urandom; m_wdata[1] = $urandom;
      sample();
      check_model();
      commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
